rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter SUM_W, default 16, checksum accumulator width in bits (8..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 bus_req  input  1  bus side requests a ROM read this cycle.
REQ-005 bus_addr  input  10  bus read address.
REQ-006 bus_oe  output  1  bus read data valid.
REQ-007 bus_data  output  8  bus read data; 0 when bus_oe=0.
REQ-008 scan_start  input  1  start a full-ROM checksum scan.
REQ-009 scan_busy  output  1  scan in progress.
REQ-010 scan_done  output  1  one-cycle pulse, scan complete.
REQ-011 scan_sum  output  SUM_W  checksum result.
REQ-012 rom_addr  output  10  address to ROM; ROM registers data on the next rising edge.
REQ-013 rom_en  output  1  ROM output enable.
REQ-014 rom_oe  input  1  ROM output valid.
REQ-015 rom_do  input  8  ROM data.

Function
REQ-016 ROM access SHALL be one read per cycle, 1-cycle latency: address in cycle N, data consumed in cycle N+1.
REQ-017 Bus SHALL have absolute priority; with bus_req=1, rom_addr=bus_addr combinationally.
REQ-018 An owner tag (NONE/BUS/SCAN) SHALL record the issuer of each cycle's read, registered for the following cycle.
REQ-019 rom_en SHALL be 1 exactly in cycles whose registered tag is not NONE.
REQ-020 bus_oe=rom_oe and bus_data=rom_do when tag=BUS; otherwise both 0.
REQ-021 Scan FSM states: IDLE, RUN, DRAIN, DONE.
REQ-022 IDLE: scan_start=1 -> RUN; scan_addr cleared to 0; accumulator cleared to 0.
REQ-023 RUN: each cycle with bus_req=0, issue scan_addr (tag SCAN) and increment scan_addr; with bus_req=1, no scan issue, scan_addr held.
REQ-024 RUN: issuing address 1023 -> DRAIN.
REQ-025 Every cycle with tag=SCAN and rom_oe=1, accumulator SHALL add zero-extended rom_do modulo 2^SUM_W.
REQ-026 DRAIN: final byte accumulated this cycle -> DONE unconditionally.
REQ-027 DONE: scan_done=1 for exactly this cycle; scan_sum valid -> IDLE.
REQ-028 scan_busy=1 in RUN and DRAIN only.
REQ-029 scan_sum SHALL hold its value from DONE until the next scan_start is accepted.
REQ-030 scan_start outside IDLE SHALL be ignored.
REQ-031 With no bus_req, scan_done SHALL assert in the cycle following edge t+1025, where t is the edge sampling scan_start; each bus_req cycle during RUN delays it by one cycle.
REQ-032 rom_addr SHALL be 0 when neither bus nor scan issues.

Reset
REQ-033 rst_n=0 at an edge: FSM->IDLE, tag->NONE, scan_addr=0, accumulator=0, scan_sum=0.
REQ-034 During reset and the first cycle after: bus_oe=0, bus_data=0, rom_en=0, scan_busy=0, scan_done=0.
REQ-035 Reset mid-scan SHALL abort the scan with no scan_done pulse.

Configuration
REQ-036 Macro ROM_SCAN_EN: defined -> scan engine present per REQ-021..031.
REQ-037 Without ROM_SCAN_EN: scan_start ignored; scan_busy, scan_done, scan_sum tied 0; tag is only NONE/BUS; bus path timing unchanged.

Verification
REQ-038 ROM all 0xFF, scan_start 1 cycle, no bus traffic -> scan_done at t+1025, scan_sum=0xFC00.
REQ-039 ROM[i]=i[7:0], bus_req held at bus_addr=0x005 for 1 cycle -> next cycle bus_oe=1, bus_data=0x05, rom_en=1.
REQ-040 Same image, scan with bus_req held 10 cycles mid-scan -> scan_done at t+1035, scan_sum=0xFE00, bus reads correct.
REQ-041 rst_n=0 at scan_addr=500 -> scan_busy=0 next cycle, no scan_done, new scan yields full correct sum.
REQ-042 ROM_SCAN_EN undefined, scan_start pulsed -> scan_busy/scan_done stay 0; bus read of 0x3FF returns 0xFF after 1 cycle.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: bus, scan and ROM port bundle for rom_arbiter
interface rom_arbiter_if #(parameter int SUM_W = 16);
  logic             bus_req;
  logic [9:0]       bus_addr;
  logic             bus_oe;
  logic [7:0]       bus_data;
  logic             scan_start;
  logic             scan_busy;
  logic             scan_done;
  logic [SUM_W-1:0] scan_sum;
  logic [9:0]       rom_addr;
  logic             rom_en;
  logic             rom_oe;
  logic [7:0]       rom_do;
  modport master(
    output bus_req, bus_addr, scan_start, rom_oe, rom_do,
    input  bus_oe, bus_data, scan_busy, scan_done, scan_sum, rom_addr, rom_en
  );
  modport slave(
    input  bus_req, bus_addr, scan_start, rom_oe, rom_do,
    output bus_oe, bus_data, scan_busy, scan_done, scan_sum, rom_addr, rom_en
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: single-port ROM shared by a priority bus and a checksum scan engine (scan engine built only with ROM_SCAN_EN)
module rom_arbiter #(
  parameter int SUM_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  rom_arbiter_if.slave io
);
  typedef enum logic [1:0] {NONE, BUS, SCAN} tag_t;
  tag_t       tag;
  logic       scan_issue;
  logic [9:0] scan_addr;
  assign io.rom_addr = io.bus_req ? io.bus_addr : scan_issue ? scan_addr : 10'd0;
  assign io.rom_en   = tag != NONE;
  assign io.bus_oe   = (tag == BUS) && io.rom_oe;
  assign io.bus_data = (tag == BUS) ? io.rom_do : 8'd0;
  // remember who issued this cycle's read so the returning data is routed next cycle
  always_ff @(posedge clk)
    if (!rst_n) tag <= NONE;
    else tag <= io.bus_req ? BUS : scan_issue ? SCAN : NONE;
`ifdef ROM_SCAN_EN
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_nxt;
  logic [SUM_W-1:0] sum;
  assign scan_issue   = (state == RUN) && !io.bus_req;
  assign acc_nxt      = acc + ((tag == SCAN && io.rom_oe) ? SUM_W'(io.rom_do) : '0);
  assign io.scan_busy = (state == RUN) || (state == DRAIN);
  assign io.scan_done = state == DONE;
  assign io.scan_sum  = sum;
  // scan sequencer: walk all addresses in bus gaps, fold returning bytes, publish sum once drained
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      scan_addr <= '0;
      acc       <= '0;
      sum       <= '0;
    end else begin
      acc <= acc_nxt;
      case (state)
        IDLE:
          if (io.scan_start) begin
            state     <= RUN;
            scan_addr <= '0;
            acc       <= '0;
          end
        RUN:
          if (scan_issue) begin
            scan_addr <= scan_addr + 10'd1;
            if (scan_addr == 10'h3ff) state <= DRAIN;
          end
        DRAIN: begin
          state <= DONE;
          sum   <= acc_nxt;
        end
        default: state <= IDLE;
      endcase
    end
`else
  assign scan_issue   = 1'b0;
  assign scan_addr    = 10'd0;
  assign io.scan_busy = 1'b0;
  assign io.scan_done = 1'b0;
  assign io.scan_sum  = '0;
`endif
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed checks of bus path, scan checksum timing and reset abort
module tb_rom_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic [7:0] mem [1024];
  logic [7:0] rom_q;
  rom_arbiter_if #(.SUM_W(16)) io ();
  rom_arbiter #(.SUM_W(16)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= mem[io.rom_addr];
  assign io.rom_oe = io.rom_en;
  assign io.rom_do = io.rom_en ? rom_q : 8'h00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic bus_read(input logic [9:0] a, input logic [7:0] d);
    io.bus_req = 1'b1;
    io.bus_addr = a;
    #1 chk("rom_addr_bus", io.rom_addr, a);
    @(posedge clk);
    #1 io.bus_req = 1'b0;
    #1;
    chk("bus_oe", io.bus_oe, 1);
    chk("bus_data", io.bus_data, d);
    chk("rom_en", io.rom_en, 1);
    chk("rom_addr_idle", io.rom_addr, 0);
    @(posedge clk);
    #1;
    chk("bus_oe_off", io.bus_oe, 0);
    chk("bus_data_off", io.bus_data, 0);
    chk("rom_en_off", io.rom_en, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_oe", io.bus_oe, 0);
    chk("rst_bus_data", io.bus_data, 0);
    chk("rst_rom_en", io.rom_en, 0);
    chk("rst_busy", io.scan_busy, 0);
    chk("rst_done", io.scan_done, 0);
    chk("rst_sum", io.scan_sum, 0);
    chk("rst_rom_addr", io.rom_addr, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rom_en", io.rom_en, 0);
    chk("post_rst_bus_oe", io.bus_oe, 0);
  endtask
  task automatic run_scan(input int nbus, input int exp_n, input logic [15:0] exp_sum);
    int n;
    logic pend;
    logic [9:0] la;
    pend = 1'b0;
    la = '0;
    n = 0;
    io.scan_start = 1'b1;
    @(posedge clk);
    #1 io.scan_start = 1'b0;
    #1 chk("busy_start", io.scan_busy, 1);
    while (n < 1200) begin
      @(posedge clk);
      #1;
      n++;
      if (pend) begin
        chk("scan_bus_oe", io.bus_oe, 1);
        chk("scan_bus_data", io.bus_data, {24'd0, la[7:0]});
      end
      pend = 1'b0;
      io.scan_start = (n == 300);
      if (n >= 400 && n < 400 + nbus) begin
        io.bus_req = 1'b1;
        io.bus_addr = 10'(n * 3);
        la = io.bus_addr;
        pend = 1'b1;
      end else io.bus_req = 1'b0;
      #1;
      if (io.scan_done) break;
    end
    io.bus_req = 1'b0;
    io.scan_start = 1'b0;
    chk("done_cycle", n, exp_n);
    chk("scan_sum", io.scan_sum, exp_sum);
    chk("busy_in_done", io.scan_busy, 0);
    @(posedge clk);
    #1;
    chk("done_pulse", io.scan_done, 0);
    chk("sum_hold", io.scan_sum, exp_sum);
  endtask
  initial begin
    io.bus_req = 1'b0;
    io.bus_addr = '0;
    io.scan_start = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    do_reset();
    bus_read(10'h005, 8'h05);
    bus_read(10'h123, 8'h23);
    bus_read(10'h200, 8'h00);
    io.bus_req = 1'b1;
    io.bus_addr = 10'h010;
    @(posedge clk);
    #1 io.bus_addr = 10'h011;
    #1 chk("b2b_data0", io.bus_data, 8'h10);
    @(posedge clk);
    #1 io.bus_req = 1'b0;
    #1 chk("b2b_data1", io.bus_data, 8'h11);
    chk("b2b_oe1", io.bus_oe, 1);
    @(posedge clk);
    #1 chk("b2b_end", io.rom_en, 0);
`ifdef ROM_SCAN_EN
    for (int i = 0; i < 1024; i++) mem[i] = 8'hff;
    run_scan(0, 1025, 16'hfc00);
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    run_scan(10, 1035, 16'hfe00);
    begin
      logic seen;
      seen = 1'b0;
      io.scan_start = 1'b1;
      @(posedge clk);
      #1 io.scan_start = 1'b0;
      repeat (500) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("abort_busy", io.scan_busy, 0);
      chk("abort_done", io.scan_done, 0);
      chk("abort_sum", io.scan_sum, 0);
      chk("abort_rom_en", io.rom_en, 0);
      repeat (20) begin
        @(posedge clk);
        #1 seen = seen | io.scan_done | io.scan_busy;
      end
      chk("abort_quiet", seen, 0);
    end
    run_scan(0, 1025, 16'hfe00);
`else
    io.scan_start = 1'b1;
    @(posedge clk);
    #1 io.scan_start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("noscan_busy", io.scan_busy, 0);
      chk("noscan_done", io.scan_done, 0);
      chk("noscan_rom_en", io.rom_en, 0);
    end
    chk("noscan_sum", io.scan_sum, 0);
`endif
    bus_read(10'h3ff, 8'hff);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
